fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined RV32I core, replacing the fixed rs1/rs2/wdata forwarding selects. It tracks destination tags of in-flight instructions in EX, MEM and WB and derives a forwarding select for each of `NUM_SRC` source operands of the instruction in EX. It detects load-use hazards at ID and keeps a one-entry retire-hold buffer, so a register file without write-through still forwards correctly. It sits beside the decode/EX boundary and drives the operand muxes in the datapath.

## Interface
- `NUM_SRC`, 3, number of source operands tracked (rs1, rs2, store data)
- `XLEN`, 32, data width of hold buffer
- `RA_W`, 5, register address width
- `HOLD_EN`, 1, 1 = retire-hold buffer active; 0 = select `wb_hold` never produced, `hold_data` tied 0
- `clk` in 1 clock; single clock domain
- `rst` in 1 synchronous, active-high reset
- `id_valid` in 1 instruction in ID is real (not bubble)
- `id_rs` in `NUM_SRC`×`RA_W` source register addresses of ID instruction
- `id_rs_used` in `NUM_SRC` per-source "operand actually read"
- `id_rd` in `RA_W` destination of ID instruction
- `id_wr` in 1 ID instruction writes `id_rd`
- `id_is_load` in 1 ID instruction is a load
- `pipe_stall` in 1 global freeze (cache miss); no stage advances
- `flush` in 1 squash ID instruction (branch taken in EX)
- `wb_data` in `XLEN` value being written back by WB instruction
- `fwd_sel` out `NUM_SRC`×2 `fwdmux_sel_t` per source of EX instruction
- `load_use_stall` out 1 hold PC/ID, inject bubble into EX
- `hold_data` out `XLEN` retire-hold buffer value

## Operation
- Stage tag = {valid, rd, wr, is_load}; EX tag also stores `rs[NUM_SRC]`, `rs_used`.
- Tags with `rd`=0 or `wr`=0 are non-producers and never match.
- `load_use_stall` = EX valid & producer & is_load & ∃i: `id_valid` & `id_rs_used[i]` & `id_rs[i]`==EX.rd.
- Advance (`pipe_stall`=0), at the edge: WB←MEM, MEM←EX; EX←bubble if `flush` or `load_use_stall`, else EX←ID fields.
- `flush` outranks `load_use_stall`; `pipe_stall` outranks both (all state frozen, `flush` ignored, upstream holds it).
- Hold capture: on advance, if WB is valid producer: hold_rd←WB.rd, `hold_data`←`wb_data`, hold_valid←1. Never cleared except by reset; every retirement overwrites.
- `fwd_sel[i]` for EX source i, only if EX valid & `rs_used[i]` & rs≠0, priority: MEM match → `ex_mem`; else WB match → `mem_wb`; else hold match (HOLD_EN) → `wb_hold`; else `reg_out`.
- MEM load never matches EX consumer (guaranteed by stall); no check required, assertion in bench.

## Timing
- Reset: all tags invalid, hold_valid=0, `hold_data`=0, `fwd_sel`=all `reg_out`, `load_use_stall`=0.
- `fwd_sel`, `load_use_stall`: combinational from registered tags and ID inputs; valid same cycle.
- Load-use: exactly one bubble per hazard (EX load moves to MEM, stall drops).
- Producer distance 1 → `ex_mem`; 2 → `mem_wb`; 3 → `wb_hold`; ≥4 → `reg_out`.
- `pipe_stall` mid-hazard: `load_use_stall` stays asserted, state frozen until release.
- Reset during stall/flush: reset wins.

## Structure
- Package `fwdmux`: `fwdmux_sel_t` 2-bit enum `reg_out`=00, `ex_mem`=01, `mem_wb`=10, `wb_hold`=11; `stage_tag_t` packed struct. Lives in the shared mux-types file, alongside the existing select packages.
- Sub-module `fwd_tag_stage`: one pipelined tag register with advance/bubble control, instantiated for EX, MEM, WB.

## Test plan
- `add x5` then `add x6,x5,x1` → next cycle `fwd_sel[0]`=01, `load_use_stall`=0.
- `lw x7` then `add x8,x7,x7` → `load_use_stall`=1 one cycle, EX bubble, then `fwd_sel[0]`=`fwd_sel[1]`=10.
- `addi x9`, two nops, `sw x9` with HOLD_EN=1, `wb_data`=0xDEADBEEF at retire → store-data `fwd_sel[2]`=11, `hold_data`=0xDEADBEEF; HOLD_EN=0 → 00.
- Writers to x0, and MEM and WB both writing x3 consumed by EX → x0 sources 00; x3 source 01 (MEM priority).
- `pipe_stall`=1 for 3 cycles during load-use hazard → tags, hold, selects unchanged, stall stays 1; single bubble after release.
- `flush`=1 with dependent-on-load instruction in ID → EX bubble, `load_use_stall` no effect, no extra bubble next cycle.

Source files
------------

// File: rtl/fwdmux_pkg.sv
// Shared operand-mux select types for the forwarding unit, plus the pipeline
// stage tag used to track in-flight destination registers.
package fwdmux;

    // Tag rd field is sized for the widest register address in use; narrower
    // addresses are zero-extended into it.
    localparam int unsigned TAG_RA_W = 8;

    typedef enum logic [1:0] {
        reg_out = 2'b00,
        ex_mem  = 2'b01,
        mem_wb  = 2'b10,
        wb_hold = 2'b11
    } fwdmux_sel_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_RA_W-1:0] rd;
        logic                wr;
        logic                is_load;
    } stage_tag_t;

    function automatic logic is_producer(input stage_tag_t t);
        return t.valid && t.wr && (t.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_tag_stage.sv
// One pipelined destination tag register; loads on advance, or inserts a
// bubble when requested.
module fwd_tag_stage
    import fwdmux::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       bubble,
    input  stage_tag_t tag_d,
    output stage_tag_t tag_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else if (advance) begin
            tag_q <= bubble ? '0 : tag_d;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks EX/MEM/WB destination tags plus
// a one-entry retire-hold buffer and selects the operand source for EX.
module fwd_scoreboard
    import fwdmux::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NUM_SRC*RA_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic [RA_W-1:0]         id_rd,
    input  logic                    id_wr,
    input  logic                    id_is_load,
    input  logic                    pipe_stall,
    input  logic                    flush,
    input  logic [XLEN-1:0]         wb_data,
    output logic [2*NUM_SRC-1:0]    fwd_sel,
    output logic                    load_use_stall,
    output logic [XLEN-1:0]         hold_data
);

    logic       advance;
    logic       bubble;
    logic       lus_hit;
    stage_tag_t id_tag;
    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;

    logic [NUM_SRC*RA_W-1:0] ex_rs;
    logic [NUM_SRC-1:0]      ex_rs_used;

    logic                hold_valid;
    logic [TAG_RA_W-1:0] hold_rd;
    logic [XLEN-1:0]     hold_q;

    assign advance = ~pipe_stall;
    assign bubble  = flush | load_use_stall;

    always_comb begin
        id_tag         = '0;
        id_tag.valid   = id_valid;
        id_tag.rd      = TAG_RA_W'(id_rd);
        id_tag.wr      = id_wr;
        id_tag.is_load = id_is_load;
    end

    always_comb begin
        lus_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (TAG_RA_W'(id_rs[i*RA_W +: RA_W]) == ex_tag.rd)) begin
                lus_hit = 1'b1;
            end
        end
        load_use_stall = is_producer(ex_tag) && ex_tag.is_load && id_valid && lus_hit;
    end

    fwd_tag_stage u_ex (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .bubble  (bubble),
        .tag_d   (id_tag),
        .tag_q   (ex_tag)
    );

    fwd_tag_stage u_mem (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .bubble  (1'b0),
        .tag_d   (ex_tag),
        .tag_q   (mem_tag)
    );

    fwd_tag_stage u_wb (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .bubble  (1'b0),
        .tag_d   (mem_tag),
        .tag_q   (wb_tag)
    );

    // Source addresses only matter while EX holds a real instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs      <= '0;
            ex_rs_used <= '0;
        end else if (advance) begin
            ex_rs      <= bubble ? '0 : id_rs;
            ex_rs_used <= bubble ? '0 : id_rs_used;
        end
    end

    // Holds the last retired value so a non-write-through register file
    // still sees it one cycle after WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_q     <= '0;
        end else if (HOLD_EN && advance && is_producer(wb_tag)) begin
            hold_valid <= 1'b1;
            hold_rd    <= wb_tag.rd;
            hold_q     <= wb_data;
        end
    end

    assign hold_data = HOLD_EN ? hold_q : '0;

    always_comb begin
        fwdmux_sel_t         sel;
        logic [TAG_RA_W-1:0] rs;
        fwd_sel = '0;
        sel     = reg_out;
        rs      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs  = TAG_RA_W'(ex_rs[i*RA_W +: RA_W]);
            sel = reg_out;
            if (ex_tag.valid && ex_rs_used[i] && (rs != '0)) begin
                if (is_producer(mem_tag) && (mem_tag.rd == rs)) begin
                    sel = ex_mem;
                end else if (is_producer(wb_tag) && (wb_tag.rd == rs)) begin
                    sel = mem_wb;
                end else if (HOLD_EN && hold_valid && (hold_rd == rs)) begin
                    sel = wb_hold;
                end
            end
            fwd_sel[2*i +: 2] = sel;
        end
    end

endmodule
